tlul_fetch_host: RTL and testbench
==================================

Name: tlul_fetch_host

Overview:
- TL-UL host (initiator) adapter.
- Converts a core-side req/gnt/rvalid memory port, as used by the instruction-fetch and LSU ports, into TL-UL A-channel requests.
- Accepts the matching D-channel responses.
- It is the opposite end of the instruction-memory device path. It sits between the core fetch unit and the TL-UL crossbar, and tracks up to MaxOutstanding in-flight transactions.

Parameters:
- MaxOutstanding, 2, maximum A-channel requests issued without a D response (1..8).
- SourceW, 8, width of a_source; must hold MaxOutstanding-1.
- SourceBase, 0, value added to the rolling ID to form a_source.

Ports:
- clock  input  1  single clock
- reset  input  1  asynchronous, active-high reset
- req_i  input  1  core request valid
- addr_i  input  32  byte address
- we_i  input  1  1=write, 0=read
- be_i  input  4  byte enables for writes
- wdata_i  input  32  write data
- gnt_o  output  1  request accepted this cycle
- rvalid_o  output  1  response valid (one-cycle pulse per response)
- rdata_o  output  32  read data, valid with rvalid_o
- err_o  output  1  response error, valid with rvalid_o
- tl_h_o  output  tlul_pkg::tl_h2d_t  TL-UL A channel plus d_ready
- tl_h_i  input  tlul_pkg::tl_d2h_t  TL-UL D channel plus a_ready

Behaviour:
- Clock and reset: single clock `clock`; reset `reset` is asynchronous, active-high.
- Reset values: outstanding count=0, source counter=0, a_valid=0, gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0. d_ready=1 at all times, including during reset.
- Room: room = (outstanding < MaxOutstanding).
- A channel, combinational from inputs:
  - a_valid = req_i & room.
  - a_address = {addr_i[31:2],2'b00}; a_size=2.
  - Read: a_opcode=Get (4), a_mask=4'hF.
  - Write with be_i==4'hF: a_opcode=PutFullData (0).
  - Other writes: a_opcode=PutPartialData (1).
  - a_mask=be_i for writes; a_data=wdata_i; a_source=SourceBase+src_cnt.
  - a_param=0; a_user carries defaults from tlul_pkg.
- Grant: gnt_o = a_valid & a_ready. The core holds req_i and all fields stable until gnt_o. The A-channel fields are held stable while a_valid=1 and a_ready=0.
- Source counter: increments on every A handshake and wraps from MaxOutstanding-1 to 0.
- Outstanding counter:
  - +1 on A handshake, -1 on D handshake.
  - Both in the same cycle leaves it unchanged.
  - Never exceeds MaxOutstanding; never underflows.
- Full: at outstanding==MaxOutstanding, a_valid=0 and gnt_o=0. A D handshake in the same cycle does not enable a same-cycle grant; the new request is issued next cycle, so room uses the registered count.
- D channel: responses are in order. A D handshake (d_valid, since d_ready=1) with outstanding>0 registers:
  - rvalid_o=1 the next cycle.
  - rdata_o=d_data for AccessAckData, 0 for AccessAck.
  - err_o=d_error.
  - Latency: one cycle from D handshake to rvalid_o.
- Spurious D: a beat with outstanding==0 is consumed and dropped; rvalid_o stays 0.
- Reset mid-operation: counters clear immediately. Responses to pre-reset requests that arrive afterwards are treated as spurious.

Optional Feature:
- Macro: TLUL_HOST_SRC_CHECK_EN.
- Defined:
  - Each issued a_source is pushed into an in-order FIFO of depth MaxOutstanding.
  - Each accepted D beat pops the head.
  - If d_source != head, err_o=1 with that response regardless of d_error.
  - The FIFO clears on reset.
- Undefined: no FIFO; d_source is ignored; err_o=d_error only.

Decomposition:
- tlul_pkg:
  - Opcode constants (Get, PutFullData, PutPartialData, AccessAck, AccessAckData) and default a_user value are taken from tlul_pkg.
  - Add to tlul_pkg: localparam AccessSizeWord=2.
- Sub-module: tlul_host_id_fifo, instantiated only under TLUL_HOST_SRC_CHECK_EN. It is a parameterised depth/width synchronous FIFO with async reset and push/pop/head/empty/full ports.

Test Plan:
- Single read: req_i=1, addr_i=32'h0000_1006, we_i=0, a_ready=1 -> same cycle a_valid=1, a_address=32'h0000_1004, a_opcode=4, a_mask=F, gnt_o=1. Then D AccessAckData d_data=32'hDEAD_BEEF -> next cycle rvalid_o=1, rdata_o=DEADBEEF, err_o=0.
- Partial write: we_i=1, be_i=4'b0011, wdata_i=32'h1234_5678 -> a_opcode=1, a_mask=3. With be_i=F -> a_opcode=0. AccessAck -> rvalid_o=1, rdata_o=0.
- Full stall: MaxOutstanding=2, three back-to-back reads with no D response -> gnt_o on cycles 1 and 2 only, a_sources 0 and 1. The third request is granted the cycle after the first D beat; its a_source is 0.
- Backpressure and simultaneous events: a_ready=0 for 3 cycles -> gnt_o=0, fields stable. A D beat coinciding with a new grant -> outstanding count unchanged.
- Errors and spurious beats: d_error=1 -> err_o=1 with rvalid_o. A D beat with no outstanding request -> no rvalid_o. Reset asserted with 2 outstanding -> a_valid=0 and count=0 immediately.
- With TLUL_HOST_SRC_CHECK_EN: issue sources 0 then 1, return d_source=1 first -> err_o=1 on that response.

Source files
------------

// File: rtl/tlul_pkg.sv
// TL-UL types, opcodes and defaults shared by the host adapter and its testbench.
package tlul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_AIW = 8;
  localparam int TL_DIW = 1;
  localparam int TL_SZW = 2;
  localparam int TL_DBW = TL_DW / 8;

  localparam logic [TL_SZW-1:0] AccessSizeWord = 2'd2;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  localparam tl_a_user_t TL_A_USER_DEFAULT = '{instr_type: 4'h9, cmd_intg: 7'h0, data_intg: 7'h0};

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic              a_valid;
    tl_a_op_e          a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    tl_a_user_t        a_user;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    tl_d_op_e          d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    tl_d_user_t        d_user;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_host_id_fifo.sv
// In-order FIFO of issued source IDs; used by tlul_fetch_host when TLUL_HOST_SRC_CHECK_EN is defined.
module tlul_host_id_fifo #(
  parameter int Depth = 2,
  parameter int Width = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [CntW-1:0]  count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CntFull);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PtrLast) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PtrLast) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tlul_fetch_host.sv
// TL-UL host adapter turning a core req/gnt/rvalid port into A/D channel traffic.
// Define TLUL_HOST_SRC_CHECK_EN to flag responses whose d_source is out of order.
module tlul_fetch_host
  import tlul_pkg::*;
#(
  parameter int MaxOutstanding = 2,
  parameter int SourceW        = 8,
  parameter int SourceBase     = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output tl_h2d_t     tl_h_o,
  input  tl_d2h_t     tl_h_i
);

  localparam int CntW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int OutW = $clog2(MaxOutstanding + 1);
  localparam logic [OutW-1:0] MaxOut  = OutW'(MaxOutstanding);
  localparam logic [CntW-1:0] SrcLast = CntW'(MaxOutstanding - 1);

  logic [OutW-1:0]    outstanding;
  logic [CntW-1:0]    src_cnt;
  logic [SourceW-1:0] a_src;
  logic               room, a_valid, a_hs, rsp_ok, rsp_err;
  logic               rvalid_q, err_q;
  logic [31:0]        rdata_q;

  // Room comes from the registered count, so a D beat never frees a slot in its own cycle.
  assign room    = (outstanding < MaxOut);
  assign a_valid = req_i & room & ~reset;
  assign a_hs    = a_valid & tl_h_i.a_ready;
  assign rsp_ok  = tl_h_i.d_valid & (outstanding != '0);
  assign a_src   = SourceW'(SourceBase) + SourceW'(src_cnt);

  always_comb begin
    tl_h_o           = '0;
    tl_h_o.a_valid   = a_valid;
    tl_h_o.a_param   = 3'h0;
    tl_h_o.a_size    = AccessSizeWord;
    tl_h_o.a_source  = TL_AIW'(a_src);
    tl_h_o.a_address = {addr_i[31:2], 2'b00};
    tl_h_o.a_data    = wdata_i;
    tl_h_o.a_user    = TL_A_USER_DEFAULT;
    tl_h_o.d_ready   = 1'b1;
    if (we_i) begin
      tl_h_o.a_opcode = (be_i == 4'hF) ? PutFullData : PutPartialData;
      tl_h_o.a_mask   = be_i;
    end else begin
      tl_h_o.a_opcode = Get;
      tl_h_o.a_mask   = 4'hF;
    end
  end

  assign gnt_o = a_hs;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      src_cnt     <= '0;
    end else begin
      if (a_hs) src_cnt <= (src_cnt == SrcLast) ? '0 : src_cnt + 1'b1;
      case ({a_hs, rsp_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef TLUL_HOST_SRC_CHECK_EN
  logic [SourceW-1:0] head_src;
  logic               fifo_empty, fifo_full;
  logic               unused_tl;

  tlul_host_id_fifo #(
    .Depth (MaxOutstanding),
    .Width (SourceW)
  ) u_id_fifo (
    .clock (clock),
    .reset (reset),
    .push  (a_hs),
    .wdata (a_src),
    .pop   (rsp_ok),
    .head  (head_src),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign rsp_err   = tl_h_i.d_error | (SourceW'(tl_h_i.d_source) != head_src);
  assign unused_tl = ^{tl_h_i.d_param, tl_h_i.d_size, tl_h_i.d_sink, tl_h_i.d_user,
                       fifo_empty, fifo_full};
`else
  logic unused_tl;

  assign rsp_err   = tl_h_i.d_error;
  assign unused_tl = ^{tl_h_i.d_param, tl_h_i.d_size, tl_h_i.d_sink, tl_h_i.d_user,
                       tl_h_i.d_source};
`endif

  // Beats arriving with nothing outstanding are consumed and dropped here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rsp_ok;
      if (rsp_ok) begin
        rdata_q <= (tl_h_i.d_opcode == AccessAckData) ? tl_h_i.d_data : '0;
        err_q   <= rsp_err;
      end
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_tlul_fetch_host.sv
// Self-checking bench for tlul_fetch_host with a response scoreboard.
module tb_tlul_fetch_host;
  import tlul_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  tl_h2d_t     h2d;
  tl_d2h_t     d2h;

  logic        a_ready, d_valid, d_err;
  tl_d_op_e    d_op;
  logic [31:0] d_data;
  logic [7:0]  d_src;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;
  exp_t sb[$];

`ifdef TLUL_HOST_SRC_CHECK_EN
  localparam logic SrcMisErr = 1'b1;
`else
  localparam logic SrcMisErr = 1'b0;
`endif

  tlul_fetch_host #(
    .MaxOutstanding (2),
    .SourceW        (8),
    .SourceBase     (0)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req_i    (req),
    .addr_i   (addr),
    .we_i     (we),
    .be_i     (be),
    .wdata_i  (wdata),
    .gnt_o    (gnt),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err),
    .tl_h_o   (h2d),
    .tl_h_i   (d2h)
  );

  always #5 clock = ~clock;

  always_comb begin
    d2h          = '0;
    d2h.a_ready  = a_ready;
    d2h.d_valid  = d_valid;
    d2h.d_opcode = d_op;
    d2h.d_size   = 2'd2;
    d2h.d_source = d_src;
    d2h.d_data   = d_data;
    d2h.d_error  = d_err;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard: every rvalid pulse must match the oldest expected response in data, error and cycle.
  always @(negedge clock) begin
    exp_t e;
    if (rvalid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_rvalid cyc=%0d rdata=%h err=%b required=no response", cyc, rdata, err);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.data || err !== e.err || cyc != e.due) begin
          failures++;
          $display("[TB] FAIL response cyc=%0d rdata=%h err=%b required cyc=%0d rdata=%h err=%b",
                   cyc, rdata, err, e.due, e.data, e.err);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      checks++;
      failures++;
      $display("[TB] FAIL missing_rvalid cyc=%0d rvalid=%b required rvalid=1 data=%h", cyc, rvalid, sb[0].data);
      void'(sb.pop_front());
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0;
    a_ready = 1'b1; d_valid = 1'b0; d_op = AccessAck; d_data = '0; d_err = 1'b0; d_src = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    sb.delete();
    step();
    reset = 1'b0;
  endtask

  // Drives one D beat for the next edge and records the response expected one cycle later.
  task automatic send_d(input tl_d_op_e op, input logic [31:0] data, input logic e, input logic [7:0] src,
                        input logic [31:0] exp_data, input logic exp_err);
    d_valid = 1'b1; d_op = op; d_data = data; d_err = e; d_src = src;
    sb.push_back('{data: exp_data, err: exp_err, due: cyc + 1});
    step();
    d_valid = 1'b0; d_err = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    req = 1'b1;
    step();
    checks++;
    if ({h2d.a_valid, gnt, rvalid, err} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl a_valid/gnt/rvalid/err=%b required 0000", {h2d.a_valid, gnt, rvalid, err});
    end
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_rdata rdata=%h required 00000000", rdata);
    end
    checks++;
    if (h2d.d_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_d_ready d_ready=%b required 1", h2d.d_ready);
    end
    req = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    req = 1'b1; addr = 32'h0000_1006; we = 1'b0; a_ready = 1'b1;
    #1;
    checks++;
    if (h2d.a_valid !== 1'b1 || gnt !== 1'b1) begin
      failures++;
      $display("[TB] FAIL read_grant a_valid=%b gnt=%b required 1 1", h2d.a_valid, gnt);
    end
    checks++;
    if (h2d.a_address !== 32'h0000_1004 || h2d.a_opcode !== 3'd4 || h2d.a_mask !== 4'hF ||
        h2d.a_size !== 2'd2 || h2d.a_source !== 8'd0) begin
      failures++;
      $display("[TB] FAIL read_fields addr=%h op=%0d mask=%h size=%0d src=%0d required 00001004 4 f 2 0",
               h2d.a_address, h2d.a_opcode, h2d.a_mask, h2d.a_size, h2d.a_source);
    end
    step();
    req = 1'b0;
    send_d(AccessAckData, 32'hDEAD_BEEF, 1'b0, 8'd0, 32'hDEAD_BEEF, 1'b0);
    step();
  endtask

  task automatic test_partial_write();
    req = 1'b1; we = 1'b1; be = 4'b0011; wdata = 32'h1234_5678; addr = 32'h0000_2000;
    #1;
    checks++;
    if (gnt !== 1'b1 || h2d.a_opcode !== 3'd1 || h2d.a_mask !== 4'h3 ||
        h2d.a_data !== 32'h1234_5678 || h2d.a_source !== 8'd1) begin
      failures++;
      $display("[TB] FAIL partial_write gnt=%b op=%0d mask=%h data=%h src=%0d required 1 1 3 12345678 1",
               gnt, h2d.a_opcode, h2d.a_mask, h2d.a_data, h2d.a_source);
    end
    step();
    be = 4'hF;
    #1;
    checks++;
    if (gnt !== 1'b1 || h2d.a_opcode !== 3'd0 || h2d.a_mask !== 4'hF || h2d.a_source !== 8'd0) begin
      failures++;
      $display("[TB] FAIL full_write gnt=%b op=%0d mask=%h src=%0d required 1 0 f 0",
               gnt, h2d.a_opcode, h2d.a_mask, h2d.a_source);
    end
    step();
    req = 1'b0; we = 1'b0;
    send_d(AccessAck, 32'hFFFF_FFFF, 1'b0, 8'd1, 32'h0, 1'b0);
    send_d(AccessAck, 32'hCAFE_F00D, 1'b0, 8'd0, 32'h0, 1'b0);
    step();
  endtask

  task automatic test_full_stall();
    apply_reset();
    req = 1'b1; we = 1'b0; addr = 32'h0000_3000;
    #1;
    checks++;
    if (gnt !== 1'b1 || h2d.a_source !== 8'd0) begin
      failures++;
      $display("[TB] FAIL stall_first gnt=%b src=%0d required 1 0", gnt, h2d.a_source);
    end
    step();
    #1;
    checks++;
    if (gnt !== 1'b1 || h2d.a_source !== 8'd1) begin
      failures++;
      $display("[TB] FAIL stall_second gnt=%b src=%0d required 1 1", gnt, h2d.a_source);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      #1;
      checks++;
      if (gnt !== 1'b0 || h2d.a_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_full[%0d] gnt=%b a_valid=%b required 0 0", i, gnt, h2d.a_valid);
      end
    end
    d_valid = 1'b1; d_op = AccessAckData; d_data = 32'h0000_0111; d_src = 8'd0;
    sb.push_back('{data: 32'h0000_0111, err: 1'b0, due: cyc + 1});
    #1;
    checks++;
    if (gnt !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_same_cycle gnt=%b required 0", gnt);
    end
    step();
    d_valid = 1'b0;
    #1;
    checks++;
    if (gnt !== 1'b1 || h2d.a_source !== 8'd0) begin
      failures++;
      $display("[TB] FAIL stall_third gnt=%b src=%0d required 1 0", gnt, h2d.a_source);
    end
    step();
    req = 1'b0;
    send_d(AccessAckData, 32'h0000_0222, 1'b0, 8'd1, 32'h0000_0222, 1'b0);
    send_d(AccessAckData, 32'h0000_0333, 1'b0, 8'd0, 32'h0000_0333, 1'b0);
    step();
  endtask

  task automatic test_backpressure();
    req = 1'b1; we = 1'b1; be = 4'b0101; wdata = 32'hAAAA_5555; addr = 32'h0000_400A; a_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (gnt !== 1'b0 || h2d.a_valid !== 1'b1 || h2d.a_address !== 32'h0000_4008 || h2d.a_opcode !== 3'd1 ||
          h2d.a_mask !== 4'h5 || h2d.a_data !== 32'hAAAA_5555 || h2d.a_source !== 8'd1) begin
        failures++;
        $display("[TB] FAIL stall_hold[%0d] gnt=%b v=%b addr=%h op=%0d mask=%h data=%h src=%0d required 0 1 00004008 1 5 aaaa5555 1",
                 i, gnt, h2d.a_valid, h2d.a_address, h2d.a_opcode, h2d.a_mask, h2d.a_data, h2d.a_source);
      end
      step();
    end
    a_ready = 1'b1;
    #1;
    checks++;
    if (gnt !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stall_release gnt=%b required 1", gnt);
    end
    step();
    we = 1'b0; addr = 32'h0000_5000;
    d_valid = 1'b1; d_op = AccessAckData; d_data = 32'h0000_0444; d_src = 8'd1;
    sb.push_back('{data: 32'h0000_0444, err: 1'b0, due: cyc + 1});
    #1;
    checks++;
    if (gnt !== 1'b1 || h2d.a_source !== 8'd0) begin
      failures++;
      $display("[TB] FAIL simul_grant gnt=%b src=%0d required 1 0", gnt, h2d.a_source);
    end
    step();
    d_valid = 1'b0; addr = 32'h0000_5004;
    #1;
    checks++;
    if (gnt !== 1'b1 || h2d.a_source !== 8'd1) begin
      failures++;
      $display("[TB] FAIL simul_next gnt=%b src=%0d required 1 1", gnt, h2d.a_source);
    end
    step();
    addr = 32'h0000_5008;
    #1;
    checks++;
    if (gnt !== 1'b0) begin
      failures++;
      $display("[TB] FAIL simul_full gnt=%b required 0", gnt);
    end
    step();
    req = 1'b0;
    send_d(AccessAckData, 32'h0000_0555, 1'b0, 8'd0, 32'h0000_0555, 1'b0);
    send_d(AccessAckData, 32'h0000_0666, 1'b0, 8'd1, 32'h0000_0666, 1'b0);
    step();
  endtask

  task automatic test_errors_spurious();
    req = 1'b1; we = 1'b0; addr = 32'h0000_6000;
    step();
    req = 1'b0;
    send_d(AccessAckData, 32'h0000_0005, 1'b1, 8'd0, 32'h0000_0005, 1'b1);
    step();
    d_valid = 1'b1; d_op = AccessAckData; d_data = 32'h0000_0777;
    step();
    d_valid = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL spurious rvalid=%b required 0", rvalid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    req = 1'b1; we = 1'b0; addr = 32'h0000_7000;
    step();
    step();
    #1;
    checks++;
    if (h2d.a_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_full a_valid=%b required 0", h2d.a_valid);
    end
    a_ready = 1'b0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (h2d.a_valid !== 1'b1 || h2d.a_source !== 8'd0) begin
      failures++;
      $display("[TB] FAIL mid_cleared a_valid=%b src=%0d required 1 0", h2d.a_valid, h2d.a_source);
    end
    req = 1'b0; a_ready = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      d_valid = 1'b1; d_op = AccessAckData; d_data = 32'h0000_0880 + i;
      step();
      d_valid = 1'b0;
      checks++;
      if (rvalid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stale_rsp[%0d] rvalid=%b required 0", i, rvalid);
      end
    end
    req = 1'b1;
    #1;
    checks++;
    if (gnt !== 1'b1 || h2d.a_source !== 8'd0) begin
      failures++;
      $display("[TB] FAIL post_reset_grant gnt=%b src=%0d required 1 0", gnt, h2d.a_source);
    end
    step();
    req = 1'b0;
    send_d(AccessAckData, 32'h0000_0999, 1'b0, 8'd0, 32'h0000_0999, 1'b0);
    step();
  endtask

  task automatic test_source_order();
    apply_reset();
    req = 1'b1; we = 1'b0; addr = 32'h0000_8000;
    #1;
    checks++;
    if (gnt !== 1'b1 || h2d.a_source !== 8'd0) begin
      failures++;
      $display("[TB] FAIL src_issue gnt=%b src=%0d required 1 0", gnt, h2d.a_source);
    end
    step();
    step();
    req = 1'b0;
    send_d(AccessAckData, 32'h0000_0010, 1'b0, 8'd1, 32'h0000_0010, SrcMisErr);
    send_d(AccessAckData, 32'h0000_0020, 1'b0, 8'd0, 32'h0000_0020, SrcMisErr);
    req = 1'b1;
    step();
    step();
    req = 1'b0;
    send_d(AccessAckData, 32'h0000_0030, 1'b0, 8'd0, 32'h0000_0030, 1'b0);
    send_d(AccessAckData, 32'h0000_0040, 1'b0, 8'd1, 32'h0000_0040, 1'b0);
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_partial_write();
    test_full_stall();
    test_backpressure();
    test_errors_spurious();
    test_reset_mid();
    test_source_order();
    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL pending_responses left=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
